// File: rtl/rvfi_csr_trace_pkg.sv
// Shared types for the RVFI CSR trace generator: CSR operation encoding,
// the per-record header kept in the trace FIFO, and a write-enable helper.
package rvfi_csr_trace_pkg;

  localparam logic [1:0] OP_RW = 2'd0;
  localparam logic [1:0] OP_RS = 2'd1;
  localparam logic [1:0] OP_RC = 2'd2;
  localparam logic [1:0] OP_RO = 2'd3;

  localparam int CSR_ADDR_W = 12;
  localparam int ORDER_W    = 64;

  typedef enum logic [1:0] {
    CSR_RW = OP_RW,
    CSR_RS = OP_RS,
    CSR_RC = OP_RC,
    CSR_RO = OP_RO
  } csr_op_e;

  // rmask is always all ones and wmask is either all ones or zero, so a
  // record only needs one write-enable bit instead of two XLEN masks.
  typedef struct packed {
    logic [CSR_ADDR_W-1:0] addr;
    logic                  wen;
    logic [ORDER_W-1:0]    order;
  } trace_hdr_t;

  // Set/clear with a zero operand leave the CSR untouched and trace no write.
  function automatic logic op_writes(csr_op_e op, logic operand_nz);
    logic result;
    result = 1'b0;
    case (op)
      CSR_RW:         result = 1'b1;
      CSR_RS, CSR_RC: result = operand_nz;
      default:        result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rvfi_csr_trace_gen_if.sv
// CSR request channel plus RVFI CSR trace output channel.
interface rvfi_csr_trace_gen_if #(
  parameter int XLEN    = 32,
  parameter int NUM_CSR = 8
);
  localparam int IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

  logic             csr_valid;
  logic             csr_ready;
  logic [1:0]       csr_op;
  logic [IDX_W-1:0] csr_idx;
  logic [11:0]      csr_addr;
  logic [XLEN-1:0]  csr_operand;

  logic             rvfi_valid;
  logic             rvfi_ready;
  logic [63:0]      rvfi_order;
  logic [XLEN-1:0]  rvfi_csr_addr;
  logic [XLEN-1:0]  rvfi_csr_rmask;
  logic [XLEN-1:0]  rvfi_csr_wmask;
  logic [XLEN-1:0]  rvfi_csr_rdata;
  logic [XLEN-1:0]  rvfi_csr_wdata;

  // Requester / trace sink side
  modport master (
    output csr_valid, csr_op, csr_idx, csr_addr, csr_operand, rvfi_ready,
    input  csr_ready, rvfi_valid, rvfi_order, rvfi_csr_addr, rvfi_csr_rmask,
           rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata
  );

  // Trace generator side
  modport slave (
    input  csr_valid, csr_op, csr_idx, csr_addr, csr_operand, rvfi_ready,
    output csr_ready, rvfi_valid, rvfi_order, rvfi_csr_addr, rvfi_csr_rmask,
           rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata
  );
endinterface

// File: rtl/rvfi_csr_trace_fifo.sv
// Trace record FIFO: combinational head read, push and pop in the same cycle
// allowed even when full. DEPTH must be a power of two so pointers wrap freely.
module rvfi_csr_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Qualify push/pop against occupancy and advance pointers/count.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while occupancy covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/rvfi_csr_trace_gen.sv
// CSR shadow file that executes RW/RS/RC/RO accesses and emits one RVFI CSR
// trace record per accepted access through an in-order FIFO.
module rvfi_csr_trace_gen
  import rvfi_csr_trace_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_CSR = 8,
  parameter int DEPTH   = 4
) (
  input logic                 clk,
  input logic                 reset,
  rvfi_csr_trace_gen_if.slave bus
);
  localparam int HDR_W = $bits(trace_hdr_t);
  localparam int REC_W = HDR_W + 2 * XLEN;

  logic [XLEN-1:0]    shadow_q [NUM_CSR];
  logic [XLEN-1:0]    shadow_d [NUM_CSR];
  logic [ORDER_W-1:0] order_q, order_d;

  csr_op_e         op;
  logic [XLEN-1:0] rdata, wdata;
  logic            wen, push, pop, fifo_full, fifo_empty, csr_ready;
  trace_hdr_t      hdr_in, hdr_out;
  logic [XLEN-1:0] out_rdata, out_wdata;
  logic [REC_W-1:0] rec_in, rec_out;

  // Execute the CSR operation on the pre-update shadow value.
  always_comb begin
    op    = csr_op_e'(bus.csr_op);
    rdata = shadow_q[bus.csr_idx];
    case (op)
      CSR_RW:  wdata = bus.csr_operand;
      CSR_RS:  wdata = rdata | bus.csr_operand;
      CSR_RC:  wdata = rdata & ~bus.csr_operand;
      default: wdata = rdata;
    endcase
    wen       = op_writes(op, |bus.csr_operand);
    pop       = ~fifo_empty & bus.rvfi_ready;
    csr_ready = ~reset & (~fifo_full | pop);
    push      = bus.csr_valid & csr_ready;
    hdr_in    = '{addr: bus.csr_addr, wen: wen, order: order_q};
    rec_in    = {hdr_in, rdata, wdata};
  end

  // Next shadow contents and order counter; the counter wraps at 2^64.
  always_comb begin
    shadow_d = shadow_q;
    order_d  = order_q;
    if (push) begin
      order_d = order_q + 64'd1;
      if (wen) shadow_d[bus.csr_idx] = wdata;
    end
  end

  // Shadow file and order counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CSR; i++) shadow_q[i] <= '0;
      order_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      order_q  <= order_d;
    end
  end

  rvfi_csr_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (rec_in),
    .pop     (pop),
    .rd_data (rec_out),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Unpack the head record; every trace field reads zero while no record is valid.
  always_comb begin
    {hdr_out, out_rdata, out_wdata} = rec_out;
    bus.csr_ready      = csr_ready;
    bus.rvfi_valid     = ~fifo_empty;
    bus.rvfi_order     = '0;
    bus.rvfi_csr_addr  = '0;
    bus.rvfi_csr_rmask = '0;
    bus.rvfi_csr_wmask = '0;
    bus.rvfi_csr_rdata = '0;
    bus.rvfi_csr_wdata = '0;
    if (!fifo_empty) begin
      bus.rvfi_order     = hdr_out.order;
      bus.rvfi_csr_addr  = XLEN'(hdr_out.addr);
      bus.rvfi_csr_rmask = '1;
      bus.rvfi_csr_wmask = hdr_out.wen ? '1 : '0;
      bus.rvfi_csr_rdata = out_rdata;
      bus.rvfi_csr_wdata = out_wdata;
    end
  end
endmodule

// File: tb/tb_rvfi_csr_trace_gen.sv
// Self-checking bench for rvfi_csr_trace_gen: directed scenarios followed by
// random traffic, compared against a queue-based model of the CSR/trace rules.
module tb_rvfi_csr_trace_gen;
  localparam int XLEN    = 32;
  localparam int NUM_CSR = 8;
  localparam int DEPTH   = 4;

  localparam logic [1:0] RW = 2'd0;
  localparam logic [1:0] RS = 2'd1;
  localparam logic [1:0] RC = 2'd2;
  localparam logic [1:0] RO = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rvfi_csr_trace_gen_if #(.XLEN(XLEN), .NUM_CSR(NUM_CSR)) bus ();

  rvfi_csr_trace_gen #(
    .XLEN    (XLEN),
    .NUM_CSR (NUM_CSR),
    .DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [63:0] order;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] m_shadow [NUM_CSR];
  logic [63:0] m_order;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CSR; i++) m_shadow[i] = 32'd0;
    exp_q.delete();
    m_order = 64'd0;
  endfunction

  // Architectural behaviour of one accepted access.
  function automatic void model_accept(logic [1:0] op, int idx, logic [11:0] addr, logic [31:0] opnd);
    rec_t r;
    r.addr  = addr;
    r.rdata = m_shadow[idx];
    case (op)
      RW: begin r.wdata = opnd;             r.wmask = 32'hFFFF_FFFF; end
      RS: begin r.wdata = r.rdata | opnd;   r.wmask = (opnd != 0) ? 32'hFFFF_FFFF : 32'd0; end
      RC: begin r.wdata = r.rdata & ~opnd;  r.wmask = (opnd != 0) ? 32'hFFFF_FFFF : 32'd0; end
      default: begin r.wdata = r.rdata;     r.wmask = 32'd0; end
    endcase
    if (r.wmask != 0) m_shadow[idx] = r.wdata;
    r.order = m_order;
    m_order = m_order + 64'd1;
    exp_q.push_back(r);
  endfunction

  task automatic drive(input bit v, input logic [1:0] op, input int idx,
                       input logic [11:0] addr, input logic [31:0] opnd, input bit rr);
    bus.csr_valid   = v;
    bus.csr_op      = op;
    bus.csr_idx     = idx[2:0];
    bus.csr_addr    = addr;
    bus.csr_operand = opnd;
    bus.rvfi_ready  = rr;
  endtask

  task automatic check_idle_zero(input string tag);
    check(tag, bus.rvfi_order | 64'(bus.rvfi_csr_addr | bus.rvfi_csr_rmask | bus.rvfi_csr_wmask
               | bus.rvfi_csr_rdata | bus.rvfi_csr_wdata), 64'd0);
  endtask

  // One clock: check handshakes and the head record at the falling edge, then
  // advance the model the way the rising edge will.
  task automatic tick();
    rec_t r;
    bit   exp_ready;
    @(negedge clk);
    exp_ready = !reset && (exp_q.size() < DEPTH || (exp_q.size() != 0 && bus.rvfi_ready));
    check("csr_ready", 64'(bus.csr_ready), 64'(exp_ready));
    check("rvfi_valid", 64'(bus.rvfi_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() == 0) begin
      check_idle_zero("idle_outputs_zero");
    end else if (bus.rvfi_ready) begin
      r = exp_q.pop_front();
      check("head_order", bus.rvfi_order, r.order);
      check("head_addr",  64'(bus.rvfi_csr_addr),  64'(r.addr));
      check("head_rmask", 64'(bus.rvfi_csr_rmask), 64'hFFFF_FFFF);
      check("head_wmask", 64'(bus.rvfi_csr_wmask), 64'(r.wmask));
      check("head_rdata", 64'(bus.rvfi_csr_rdata), 64'(r.rdata));
      check("head_wdata", 64'(bus.rvfi_csr_wdata), 64'(r.wdata));
    end
    if (!reset && bus.csr_valid && exp_ready)
      model_accept(bus.csr_op, int'(bus.csr_idx), bus.csr_addr, bus.csr_operand);
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] rd, input logic [31:0] wd,
                            input logic [31:0] wm, input logic [63:0] ord);
    check({tag, "_valid"}, 64'(bus.rvfi_valid), 64'd1);
    check({tag, "_rdata"}, 64'(bus.rvfi_csr_rdata), 64'(rd));
    check({tag, "_wdata"}, 64'(bus.rvfi_csr_wdata), 64'(wd));
    check({tag, "_wmask"}, 64'(bus.rvfi_csr_wmask), 64'(wm));
    check({tag, "_order"}, bus.rvfi_order, ord);
  endtask

  initial begin
    int op_r;
    logic [31:0] opnd;

    // Reset state
    drive(0, RW, 0, 12'h000, 32'd0, 1);
    model_reset();
    #2;
    check("reset_valid", 64'(bus.rvfi_valid), 64'd0);
    check("reset_csr_ready", 64'(bus.csr_ready), 64'd0);
    check_idle_zero("reset_outputs_zero");
    tick();
    tick();
    reset = 1'b0;

    // RW then RS then RC on the same entry, back to back
    drive(1, RW, 2, 12'h340, 32'hDEAD_BEEF, 1); tick();
    check_head("rw", 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 64'd0);
    check("rw_addr", 64'(bus.rvfi_csr_addr), 64'h340);
    drive(1, RS, 2, 12'h340, 32'h0000_00F0, 1); tick();
    check_head("rs", 32'hDEAD_BEEF, 32'hDEAD_BEFF, 32'hFFFF_FFFF, 64'd1);
    drive(1, RC, 2, 12'h340, 32'h0000_00FF, 1); tick();
    check_head("rc", 32'hDEAD_BEFF, 32'hDEAD_BE00, 32'hFFFF_FFFF, 64'd2);

    // Non-writing accesses
    drive(1, RS, 2, 12'h340, 32'd0, 1); tick();
    check_head("rs_zero", 32'hDEAD_BE00, 32'hDEAD_BE00, 32'd0, 64'd3);
    drive(1, RO, 2, 12'h340, $urandom(), 1); tick();
    check_head("ro", 32'hDEAD_BE00, 32'hDEAD_BE00, 32'd0, 64'd4);
    drive(1, RO, 2, 12'h340, 32'd0, 1); tick();
    check_head("shadow_kept", 32'hDEAD_BE00, 32'hDEAD_BE00, 32'd0, 64'd5);
    drive(0, RW, 0, 12'h000, 32'd0, 1); tick(); tick();

    // Fill the FIFO, then push and pop in the same cycle while full
    reset = 1'b1; model_reset(); tick(); reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, RW, $urandom_range(0, NUM_CSR-1), 12'($urandom()), $urandom(), 0);
      tick();
    end
    drive(1, RW, 5, 12'h305, 32'h5555_5555, 0);
    #1 check("full_csr_ready", 64'(bus.csr_ready), 64'd0);
    tick();
    drive(1, RW, 5, 12'h305, 32'h5555_5555, 1);
    #1 check("full_pushpop_ready", 64'(bus.csr_ready), 64'd1);
    tick();
    check("full_pushpop_head", bus.rvfi_order, 64'd1);
    drive(1, RS, 6, 12'h306, 32'h0F0F_0000, 1); tick();
    drive(0, RW, 0, 12'h000, 32'd0, 1);
    repeat (DEPTH + 2) tick();

    // Reset with records queued
    for (int i = 0; i < 3; i++) begin
      drive(1, RW, 2, 12'h340, $urandom() | 32'd1, 0);
      tick();
    end
    reset = 1'b1;
    #1;
    check("midreset_valid", 64'(bus.rvfi_valid), 64'd0);
    check("midreset_csr_ready", 64'(bus.csr_ready), 64'd0);
    check_idle_zero("midreset_outputs_zero");
    model_reset();
    tick();
    reset = 1'b0;
    drive(1, RO, 2, 12'h340, 32'd0, 1); tick();
    check_head("post_reset_ro", 32'd0, 32'd0, 32'd0, 64'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      op_r = $urandom_range(0, 3);
      opnd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      drive($urandom_range(0, 9) < 7, op_r[1:0], $urandom_range(0, NUM_CSR-1),
            12'($urandom()), opnd, $urandom_range(0, 9) < 6);
      tick();
    end
    drive(0, RW, 0, 12'h000, 32'd0, 1);
    repeat (DEPTH + 2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/rvfi_csr_trace_gen.md
RVFI_CSR_TRACE_GEN -- requirements
Module: rvfi_csr_trace_gen

Interface
REQ-001 Parameter XLEN, default 32, data/mask width of all CSR trace fields.
REQ-002 Parameter NUM_CSR, default 8, number of shadow CSR entries.
REQ-003 Parameter DEPTH, default 4, trace FIFO entries (power of two, >=2).
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port csr_valid  input  1  CSR access request present.
REQ-007 Port csr_ready  output  1  request accepted when csr_valid & csr_ready.
REQ-008 Port csr_op  input  2  0=RW, 1=RS (set), 2=RC (clear), 3=RO (read-only).
REQ-009 Port csr_idx  input  $clog2(NUM_CSR)  shadow entry selected.
REQ-010 Port csr_addr  input  12  architectural CSR address, traced only.
REQ-011 Port csr_operand  input  XLEN  write/set/clear operand.
REQ-012 Port rvfi_valid  output  1  trace record at FIFO head.
REQ-013 Port rvfi_ready  input  1  sink consumes head when rvfi_valid & rvfi_ready.
REQ-014 Port rvfi_order  output  64  record sequence number.
REQ-015 Ports rvfi_csr_addr, rvfi_csr_rmask, rvfi_csr_wmask, rvfi_csr_rdata, rvfi_csr_wdata  output  XLEN each  trace fields consumed by the unified RVFI CSR monitor interface.

Function
REQ-016 On accept: rdata = shadow[csr_idx] (pre-update value); rmask = all ones.
REQ-017 wdata: RW -> operand; RS -> rdata|operand; RC -> rdata&~operand; RO -> rdata.
REQ-018 wmask: RW -> all ones; RS/RC -> all ones if operand!=0 else 0; RO -> 0.
REQ-019 shadow[csr_idx] <= wdata on the accepting edge only when wmask!=0.
REQ-020 Back-to-back requests to same csr_idx: second sees first's write (no hazard window).
REQ-021 rvfi_csr_addr = csr_addr zero-extended to XLEN.
REQ-022 Each accepted request pushes one record {addr, rmask, wmask, rdata, wdata, order} into FIFO; order = push counter value, counter +1 per push, 64-bit wrap to 0.
REQ-023 Latency: request accepted at edge N with FIFO empty -> rvfi_valid=1 in cycle following edge N.
REQ-024 rvfi_valid = FIFO not empty; head popped on rvfi_valid & rvfi_ready.
REQ-025 csr_ready = !full | (rvfi_valid & rvfi_ready) (push and pop in same cycle when full allowed); csr_ready=0 while reset high.
REQ-026 Simultaneous push and pop: occupancy unchanged, both pointers advance.
REQ-027 Read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-028 All rvfi_csr_* and rvfi_order outputs = 0 whenever rvfi_valid=0.
REQ-029 Records leave strictly in acceptance order; none dropped or duplicated.

Reset
REQ-030 Reset clears shadow array, FIFO pointers, occupancy, order counter to 0.
REQ-031 During/after reset: rvfi_valid=0, all trace outputs 0; reset mid-operation discards queued records.

Structure
REQ-032 Package rvfi_csr_trace_pkg holds csr_op enum, trace record struct typedef, op encoding constants.
REQ-033 FIFO implemented as sub-module rvfi_csr_trace_fifo (parameterised record width, DEPTH).

Verification
REQ-034 After reset, RW idx2 operand 0xDEADBEEF, rvfi_ready=1 -> next cycle rvfi_valid=1, rdata 0, wdata 0xDEADBEEF, wmask 0xFFFFFFFF, order 0.
REQ-035 Then RS idx2 0x000000F0, then RC idx2 0x000000FF -> wdata 0xDEADBEFF (rdata 0xDEADBEEF), then wdata 0xDEADBE00 (rdata 0xDEADBEFF), orders 1,2.
REQ-036 RS idx2 operand 0 and RO idx2 -> wmask 0, wdata=rdata=0xDEADBE00, shadow unchanged.
REQ-037 rvfi_ready=0, push 4 -> csr_ready=0 on 5th; raise rvfi_ready with csr_valid held -> push/pop same cycle, output orders 0..5 contiguous.
REQ-038 Assert reset with 3 queued records -> rvfi_valid=0, outputs 0; next RO idx2 -> rdata 0, order 0.
